// File: rtl/checker_resp_monitor.sv
`timescale 1ns/1ps
// Purpose : compacts a window of checker-FSM outputs y1..y11 into a 16-bit MISR
//           signature plus active / multi-hot cycle counts.
// Latency : start->busy 1 cycle; last enabled sample->sig_valid 1 cycle.
// Backpressure: result is held in DONE until rd_ack; start in DONE needs rd_ack.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   y_in[10:0]            monitored outputs, bit0=y1 .. bit10=y11
//   start, abort          open a window / cancel a window in progress
//   sample_en             qualifies y_in for this cycle
//   rd_ack                consumer accepts the result shown in DONE
//   busy, sig_valid       high in COLLECT / high in DONE
//   signature             MISR result
//   active_cnt, multi_cnt samples with y_in != 0 / with two or more bits set
//   cnt_sat               sticky: a counter reached all-ones this window
module checker_resp_monitor #(
    parameter int          WINDOW    = 64,
    parameter logic [15:0] MISR_POLY = 16'h1021,
    parameter logic [15:0] MISR_SEED = 16'h0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [10:0]      y_in,
    input  logic             start,
    input  logic             abort,
    input  logic             sample_en,
    input  logic             rd_ack,
    output logic             busy,
    output logic             sig_valid,
    output logic [15:0]      signature,
    output logic [CNT_W-1:0] active_cnt,
    output logic [CNT_W-1:0] multi_cnt,
    output logic             cnt_sat
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Sample counter is sized for the full legal WINDOW range, independent of
    // the event-counter width.
    localparam logic [15:0]      LAST_SAMPLE = 16'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t      state;
    logic [15:0] samp_cnt;

    logic [10:0] y_q;
    logic [15:0] sig_next;
    logic        is_active;
    logic        is_multi;
    logic        go_collect;
    logic        go_abort;
    logic        do_sample;
    logic        last_sample;

    // Gate y_in with sample_en so that garbage (or X) on a disabled cycle can
    // never reach the signature or counters.
    assign y_q       = sample_en ? y_in : 11'd0;
    assign sig_next  = {signature[14:0], 1'b0}
                     ^ (signature[15] ? MISR_POLY : 16'h0000)
                     ^ {5'b0, y_q};
    assign is_active = |y_q;
    // Clearing the lowest set bit leaves something only if >= 2 bits were set.
    assign is_multi  = |(y_q & (y_q - 11'd1));

    assign go_collect  = ((state == IDLE) && start) ||
                         ((state == DONE) && start && rd_ack);
    assign go_abort    = (state == COLLECT) && abort;
    assign do_sample   = (state == COLLECT) && !abort && sample_en;
    assign last_sample = (samp_cnt == LAST_SAMPLE);

    // Control FSM with registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            sig_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= COLLECT;
                        busy  <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (sample_en && last_sample) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        sig_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (rd_ack) begin
                        sig_valid <= 1'b0;
                        if (start) begin
                            state <= COLLECT;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    sig_valid <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: results survive rd_ack back to IDLE and are only cleared by a
    // new window or an abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            signature  <= MISR_SEED;
            active_cnt <= '0;
            multi_cnt  <= '0;
            cnt_sat    <= 1'b0;
            samp_cnt   <= 16'd0;
        end else if (go_collect || go_abort) begin
            signature  <= MISR_SEED;
            active_cnt <= '0;
            multi_cnt  <= '0;
            cnt_sat    <= 1'b0;
            samp_cnt   <= 16'd0;
        end else if (do_sample) begin
            signature <= sig_next;
            samp_cnt  <= samp_cnt + 16'd1;
            if (is_active && (active_cnt != CNT_MAX)) begin
                active_cnt <= active_cnt + 1'b1;
            end
            if (is_multi && (multi_cnt != CNT_MAX)) begin
                multi_cnt <= multi_cnt + 1'b1;
            end
            // Any increment that lands on (or presses against) all-ones marks
            // the window as saturated.
            if ((is_active && (active_cnt >= CNT_MAX - 1'b1)) ||
                (is_multi  && (multi_cnt  >= CNT_MAX - 1'b1))) begin
                cnt_sat <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_checker_resp_monitor.sv
`timescale 1ns/1ps
module tb_checker_resp_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Main instance: WINDOW=4, seed 0, 16-bit counters.
    logic        start, abort, sen, ack;
    logic [10:0] y;
    logic        busy, sv, sat;
    logic [15:0] sig, act, mul;

    // Feedback instance: WINDOW=1, seed 16'h8000.
    logic        fb_start, fb_abort, fb_sen, fb_ack;
    logic [10:0] fb_y;
    logic        fb_busy, fb_sv, fb_sat;
    logic [15:0] fb_sig, fb_act, fb_mul;

    // Saturation instance: WINDOW=6, 2-bit counters.
    logic        st_start, st_abort, st_sen, st_ack;
    logic [10:0] st_y;
    logic        st_busy, st_sv, st_sat;
    logic [15:0] st_sig;
    logic [1:0]  st_act, st_mul;

    checker_resp_monitor #(.WINDOW(4)) u_main (
        .clk(clk), .rst(rst), .y_in(y), .start(start), .abort(abort),
        .sample_en(sen), .rd_ack(ack), .busy(busy), .sig_valid(sv),
        .signature(sig), .active_cnt(act), .multi_cnt(mul), .cnt_sat(sat)
    );

    checker_resp_monitor #(.WINDOW(1), .MISR_SEED(16'h8000)) u_fb (
        .clk(clk), .rst(rst), .y_in(fb_y), .start(fb_start), .abort(fb_abort),
        .sample_en(fb_sen), .rd_ack(fb_ack), .busy(fb_busy), .sig_valid(fb_sv),
        .signature(fb_sig), .active_cnt(fb_act), .multi_cnt(fb_mul), .cnt_sat(fb_sat)
    );

    checker_resp_monitor #(.WINDOW(6), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .y_in(st_y), .start(st_start), .abort(st_abort),
        .sample_en(st_sen), .rd_ack(st_ack), .busy(st_busy), .sig_valid(st_sv),
        .signature(st_sig), .active_cnt(st_act), .multi_cnt(st_mul), .cnt_sat(st_sat)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic        busy;
        logic        sv;
        logic [15:0] sig;
        logic [15:0] act;
        logic [15:0] mul;
        logic        sat;
    } exp_t;

    exp_t        flag_q[$];   // expected visible state after each driven cycle
    exp_t        res_q[$];    // expected completed-window results
    int          mode = 0;    // 0 idle, 1 collecting, 2 result shown
    logic [10:0] win[$];      // samples accepted in the current/last window

    function automatic logic [15:0] fold(input logic [15:0] seed, input logic [10:0] ys[$]);
        logic [15:0] s;
        s = seed;
        foreach (ys[i]) begin
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {5'b0, ys[i]};
        end
        return s;
    endfunction

    function automatic int n_active(input logic [10:0] ys[$]);
        int n = 0;
        foreach (ys[i]) if (ys[i] != 11'd0) n++;
        return n;
    endfunction

    function automatic int n_multi(input logic [10:0] ys[$]);
        int n = 0;
        foreach (ys[i]) if ($countones(ys[i]) >= 2) n++;
        return n;
    endfunction

    function automatic exp_t view();
        exp_t e;
        e.busy = (mode == 1);
        e.sv   = (mode == 2);
        e.sig  = fold(16'h0000, win);
        e.act  = 16'(n_active(win));
        e.mul  = 16'(n_multi(win));
        e.sat  = 1'b0;
        return e;
    endfunction

    // One main-instance cycle: drive on negedge, predict the post-edge state.
    task automatic cyc(input logic s, input logic a, input logic e,
                       input logic [10:0] yy, input logic k);
        @(negedge clk);
        start = s; abort = a; sen = e; ack = k;
        y = e ? yy : 11'($urandom);
        case (mode)
            0: if (s) begin mode = 1; win.delete(); end
            1: begin
                if (a) begin
                    mode = 0; win.delete();
                end else if (e) begin
                    win.push_back(yy);
                    if (win.size() == 4) begin
                        mode = 2;
                        res_q.push_back(view());
                    end
                end
            end
            default: if (k) begin
                if (s) begin mode = 1; win.delete(); end
                else mode = 0;
            end
        endcase
        flag_q.push_back(view());
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 11'd0, 1'b0);
    endtask

    task automatic window_of_ones();
        cyc(1'b1, 1'b0, 1'b0, 11'd0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 11'h001, 1'b0);
    endtask

    // ---------------- monitor ----------------
    logic sv_prev = 1'b0;
    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (flag_q.size() > 0) begin
                e = flag_q.pop_front();
                chk("busy", busy, e.busy);
                chk("sig_valid", sv, e.sv);
                chk("signature", sig, e.sig);
                chk("active_cnt", act, e.act);
                chk("multi_cnt", mul, e.mul);
                chk("cnt_sat", sat, e.sat);
            end
            if (sv && !sv_prev) begin
                if (res_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL result_unexpected: sig_valid rose with signature %0h, none expected", sig);
                end else begin
                    e = res_q.pop_front();
                    chk("result_sig", sig, e.sig);
                    chk("result_active", act, e.act);
                    chk("result_multi", mul, e.mul);
                end
            end
            sv_prev = sv;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [10:0] ys[$];
        logic [10:0] r;
        rst = 1'b1;
        {start, abort, sen, ack} = '0; y = '0;
        {fb_start, fb_abort, fb_sen, fb_ack} = '0; fb_y = '0;
        {st_start, st_abort, st_sen, st_ack} = '0; st_y = '0;
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_sig_valid", sv, 1'b0);
        chk("rst_signature", sig, 16'h0000);
        chk("rst_active", act, 16'd0);
        chk("rst_multi", mul, 16'd0);
        chk("rst_sat", sat, 1'b0);
        chk("rst_fb_signature", fb_sig, 16'h8000);
        chk("rst_sat_cnt_sat", st_sat, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Scenario 1: four samples of y1 -> 0x000F.
        window_of_ones();
        @(posedge clk); #2;
        chk("s1_sig", sig, 16'h000F);
        chk("s1_active", act, 16'd4);
        chk("s1_multi", mul, 16'd0);
        chk("s1_valid", sv, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 11'd0, 1'b1);
        @(posedge clk); #2;
        chk("s1_ack_valid", sv, 1'b0);
        chk("s1_ack_hold", sig, 16'h000F);

        // Scenario 2: sparse samples with gaps.
        cyc(1'b1, 1'b0, 1'b0, 11'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 11'h000, 1'b0); idle_cycles(2);
        cyc(1'b0, 1'b0, 1'b1, 11'h048, 1'b0); idle_cycles(2);
        cyc(1'b0, 1'b0, 1'b1, 11'h000, 1'b0); idle_cycles(2);
        chk("s2_still_busy", busy, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 11'h7FF, 1'b0);
        @(posedge clk); #2;
        chk("s2_active", act, 16'd2);
        chk("s2_multi", mul, 16'd2);
        chk("s2_valid", sv, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 11'd0, 1'b1);

        // Scenario 4: abort together with sample_en after two samples.
        cyc(1'b1, 1'b0, 1'b0, 11'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 11'h001, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 11'h001, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 11'h005, 1'b0);
        @(posedge clk); #2;
        chk("s4_busy", busy, 1'b0);
        chk("s4_sig", sig, 16'h0000);
        chk("s4_active", act, 16'd0);
        window_of_ones();
        @(posedge clk); #2;
        chk("s4_rerun_sig", sig, 16'h000F);

        // Scenario 5: rd_ack+start from DONE, then rd_ack alone.
        cyc(1'b1, 1'b0, 1'b0, 11'd0, 1'b1);
        @(posedge clk); #2;
        chk("s5_busy", busy, 1'b1);
        chk("s5_valid", sv, 1'b0);
        chk("s5_active", act, 16'd0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 11'h003, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 11'd0, 1'b1);
        @(posedge clk); #2;
        chk("s5_idle_busy", busy, 1'b0);
        chk("s5_hold_multi", mul, 16'd4);

        // Scenario 6: asynchronous reset mid-window.
        cyc(1'b1, 1'b0, 1'b0, 11'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 11'h001, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 11'h001, 1'b0);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("s6_busy", busy, 1'b0);
        chk("s6_valid", sv, 1'b0);
        chk("s6_sig", sig, 16'h0000);
        chk("s6_active", act, 16'd0);
        mode = 0; win.delete();
        @(negedge clk);
        {start, abort, sen, ack} = '0;
        @(negedge clk);
        rst = 1'b0;
        window_of_ones();
        @(posedge clk); #2;
        chk("s6_after_sig", sig, 16'h000F);
        cyc(1'b0, 1'b0, 1'b0, 11'd0, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 3))
                0:       r = 11'd0;
                1:       r = 11'd1 << $urandom_range(0, 10);
                default: r = 11'($urandom);
            endcase
            cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 3) != 0), r, ($urandom_range(0, 2) == 0));
        end
        repeat (2) @(posedge clk);
        #2;
        chk("flag_q_drained", 32'(flag_q.size()), 32'd0);
        chk("res_q_drained", 32'(res_q.size()), 32'd0);

        // Scenario 3: MISR feedback with seed 0x8000, WINDOW=1.
        @(negedge clk); fb_start = 1'b1;
        @(negedge clk); fb_start = 1'b0;
        chk("s3_busy", fb_busy, 1'b1);
        fb_sen = 1'b1; fb_y = 11'd0;
        @(posedge clk); #2;
        chk("s3_valid", fb_sv, 1'b1);
        chk("s3_busy_done", fb_busy, 1'b0);
        chk("s3_sig", fb_sig, 16'h1021);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            fb_sen = 1'b0; fb_y = 11'($urandom); fb_ack = 1'b1; fb_start = 1'b1;
            @(negedge clk);
            fb_ack = 1'b0; fb_start = 1'b0; fb_sen = 1'b1;
            r = 11'($urandom); fb_y = r;
            ys.delete(); ys.push_back(r);
            @(posedge clk); #2;
            chk("s3_rand_sig", fb_sig, fold(16'h8000, ys));
            chk("s3_rand_active", fb_act, 16'(n_active(ys)));
        end
        @(negedge clk); fb_sen = 1'b0;

        // CNT_W=2: five active samples saturate the counters.
        @(negedge clk); st_start = 1'b1;
        @(negedge clk); st_start = 1'b0;
        ys.delete();
        for (int i = 0; i < 6; i++) begin
            st_sen = 1'b1;
            st_y = (i < 5) ? 11'h003 : 11'h000;
            ys.push_back(st_y);
            @(negedge clk);
        end
        st_sen = 1'b0;
        @(posedge clk); #2;
        chk("sat_valid", st_sv, 1'b1);
        chk("sat_active", st_act, 2'd3);
        chk("sat_multi", st_mul, 2'd3);
        chk("sat_flag", st_sat, 1'b1);
        chk("sat_sig", st_sig, fold(16'h0000, ys));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
